// File: rtl/chroma_blend_pipe.sv
// Pipelined chroma-key mixer: 3-stage key detect / alpha blend with valid-ready and SOF sideband.
// Optional per-frame keyed-pixel statistics are enabled with the CHROMA_STATS_EN macro.
module chroma_blend_pipe #(
    parameter int COLOR_W = 10,
    parameter int ALPHA_W = 10,
    parameter int CNT_W   = 20
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    input  logic                   iValid,
    output logic                   oReady,
    input  logic                   iSOF,
    input  logic [COLOR_W-1:0]     iRed,
    input  logic [COLOR_W-1:0]     iGreen,
    input  logic [COLOR_W-1:0]     iBlue,
    input  logic [COLOR_W-1:0]     imVGA_R,
    input  logic [COLOR_W-1:0]     imVGA_G,
    input  logic [COLOR_W-1:0]     imVGA_B,
    input  logic [ALPHA_W-1:0]     iTransparencia,
    input  logic [COLOR_W-1:0]     iKeyThrG,
    input  logic [COLOR_W-1:0]     iKeyThrRB,
    output logic                   oValid,
    input  logic                   iReady,
    output logic                   oSOF,
    output logic [3*COLOR_W-1:0]   oCn,
    output logic                   oKeyFlag,
    output logic [CNT_W-1:0]       oKeyCount,
    output logic                   oCountStb
);
    localparam int AE_W = ALPHA_W + 1;
    localparam int PW   = ALPHA_W + COLOR_W + 1;
    localparam logic [AE_W-1:0]    AE_ONE = AE_W'(1) << ALPHA_W;
    localparam logic [PW-1:0]      HALF   = PW'(1) << (ALPHA_W - 1);
    localparam logic [PW-1:0]      MAXC   = PW'((1 << COLOR_W) - 1);

    logic en, take;
    assign en     = iReady || !oValid;
    assign oReady = en;
    assign take   = iValid && en;

    logic [ALPHA_W-1:0] alpha_q, alpha_cur;
    logic [AE_W-1:0]    ae_in;
    logic               key_in;

    // An SOF pixel already blends with the alpha it carries.
    assign alpha_cur = (take && iSOF) ? iTransparencia : alpha_q;
    assign ae_in     = {1'b0, alpha_cur} + {{ALPHA_W{1'b0}}, alpha_cur[ALPHA_W-1]};
    assign key_in    = (iGreen > iKeyThrG) && (iRed < iKeyThrRB) && (iBlue < iKeyThrRB);

    logic                       v1, sof1, key1;
    logic [AE_W-1:0]            ae1;
    logic [2:0][COLOR_W-1:0]    fg1, bg1;
    logic                       v2, sof2, key2;
    logic [2:0][COLOR_W-1:0]    bg2;
    logic [2:0][PW-1:0]         p2;
    logic [2:0][COLOR_W-1:0]    blend;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            alpha_q <= '0;
            v1      <= 1'b0;
            sof1    <= 1'b0;
            key1    <= 1'b0;
            ae1     <= '0;
            fg1     <= '0;
            bg1     <= '0;
            v2      <= 1'b0;
            sof2    <= 1'b0;
            key2    <= 1'b0;
            bg2     <= '0;
            p2      <= '0;
        end else begin
            if (take && iSOF)
                alpha_q <= iTransparencia;
            if (en) begin
                v1 <= iValid;
                if (iValid) begin
                    sof1 <= iSOF;
                    key1 <= key_in;
                    ae1  <= ae_in;
                    fg1  <= {iRed, iGreen, iBlue};
                    bg1  <= {imVGA_R, imVGA_G, imVGA_B};
                end
                v2 <= v1;
                if (v1) begin
                    sof2 <= sof1;
                    key2 <= key1;
                    bg2  <= bg1;
                    for (int c = 0; c < 3; c++)
                        p2[c] <= PW'(ae1) * PW'(fg1[c]) + PW'(AE_ONE - ae1) * PW'(bg1[c]);
                end
            end
        end
    end

    always_comb begin
        logic [PW-1:0] sh;
        blend = '0;
        sh    = '0;
        for (int c = 0; c < 3; c++) begin
            sh       = (p2[c] + HALF) >> ALPHA_W;
            blend[c] = (sh > MAXC) ? MAXC[COLOR_W-1:0] : sh[COLOR_W-1:0];
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oValid   <= 1'b0;
            oSOF     <= 1'b0;
            oKeyFlag <= 1'b0;
            oCn      <= '0;
        end else if (en) begin
            oValid <= v2;
            if (v2) begin
                oSOF     <= sof2;
                oKeyFlag <= key2;
                oCn      <= key2 ? bg2 : blend;
            end
        end
    end

`ifdef CHROMA_STATS_EN
    logic [CNT_W-1:0] key_cnt;
    logic             out_xfer;
    assign out_xfer = oValid && iReady;

    // A frame's SOF pixel starts the next count, so it seeds the counter itself.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            key_cnt   <= '0;
            oKeyCount <= '0;
            oCountStb <= 1'b0;
        end else begin
            oCountStb <= 1'b0;
            if (out_xfer && oSOF) begin
                oKeyCount <= key_cnt;
                oCountStb <= 1'b1;
                key_cnt   <= oKeyFlag ? CNT_W'(1) : '0;
            end else if (out_xfer && oKeyFlag && (key_cnt != {CNT_W{1'b1}})) begin
                key_cnt <= key_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign oKeyCount = '0;
    assign oCountStb = 1'b0;
`endif

endmodule

// File: tb/tb_chroma_blend_pipe.sv
// Scoreboarded bench for chroma_blend_pipe: key detect, blend, thresholds, backpressure, alpha latch, stats, reset.
module tb_chroma_blend_pipe;
    localparam int CW = 10;
    localparam int AW = 10;
    localparam int NW = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            in_valid = 1'b0, in_sof = 1'b0, out_ready_ds = 1'b1;
    logic [CW-1:0]   r = '0, g = '0, b = '0, ir = '0, ig = '0, ib = '0;
    logic [AW-1:0]   tr = '0;
    logic [CW-1:0]   thr_g = 10'h1FF, thr_rb = 10'h1FF;
    logic            ready, out_valid, out_sof, key_flag, cnt_stb;
    logic [3*CW-1:0] cn;
    logic [NW-1:0]   key_count;

    chroma_blend_pipe #(.COLOR_W(CW), .ALPHA_W(AW), .CNT_W(NW)) dut (
        .iCLK(clk), .iRST(rst), .iValid(in_valid), .oReady(ready), .iSOF(in_sof),
        .iRed(r), .iGreen(g), .iBlue(b), .imVGA_R(ir), .imVGA_G(ig), .imVGA_B(ib),
        .iTransparencia(tr), .iKeyThrG(thr_g), .iKeyThrRB(thr_rb),
        .oValid(out_valid), .iReady(out_ready_ds), .oSOF(out_sof), .oCn(cn),
        .oKeyFlag(key_flag), .oKeyCount(key_count), .oCountStb(cnt_stb)
    );

    typedef struct packed { logic sof; logic key; logic [3*CW-1:0] cn; } exp_t;
    exp_t sb[$];
    int n_chk = 0, n_pass = 0, stb_cnt = 0;
    logic [AW-1:0] m_alpha = '0;

    function automatic logic [CW-1:0] blend_ch(input logic [CW-1:0] f, input logic [CW-1:0] bk,
                                               input logic [AW-1:0] a);
        longint ae, p, res;
        ae  = longint'(a) + longint'(a[AW-1]);
        p   = ae * longint'(f) + (longint'(1 << AW) - ae) * longint'(bk);
        res = (p + longint'(1 << (AW - 1))) >> AW;
        if (res > 1023) res = 1023;
        return CW'(res);
    endfunction

    task automatic send(input logic sof, input logic [3*CW-1:0] fg, input logic [3*CW-1:0] bg,
                        input logic [AW-1:0] alpha);
        exp_t e;
        logic acc;
        int k;
        logic kf;
        {r, g, b}    = fg;
        {ir, ig, ib} = bg;
        in_sof   = sof;
        tr       = alpha;
        in_valid = 1'b1;
        if (sof) m_alpha = alpha;
        kf = (fg[2*CW-1:CW] > thr_g) && (fg[3*CW-1:2*CW] < thr_rb) && (fg[CW-1:0] < thr_rb);
        e.sof = sof;
        e.key = kf;
        e.cn  = kf ? bg : {blend_ch(fg[3*CW-1:2*CW], bg[3*CW-1:2*CW], m_alpha),
                           blend_ch(fg[2*CW-1:CW], bg[2*CW-1:CW], m_alpha),
                           blend_ch(fg[CW-1:0], bg[CW-1:0], m_alpha)};
        sb.push_back(e);
        k = 0;
        acc = 1'b0;
        while (!acc && k < 100) begin
            @(negedge clk);
            acc = ready;
            @(posedge clk);
            #1;
            k++;
        end
        if (!acc) begin
            n_chk++;
            $display("FAIL send_accept: input not accepted within %0d cycles", k);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 80) begin
            @(posedge clk);
            k++;
        end
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain: %0d outputs still pending, required 0", sb.size());
    endtask

    // Scoreboard monitor: compares every output transfer against the queued expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready_ds) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_out: got cn=%h with empty scoreboard", cn);
            end else begin
                exp_t e;
                e = sb.pop_front();
                n_chk += 3;
                if (cn !== e.cn) $display("FAIL out_cn: got %h, required %h", cn, e.cn);
                else n_pass++;
                if (key_flag !== e.key) $display("FAIL out_key: got %b, required %b", key_flag, e.key);
                else n_pass++;
                if (out_sof !== e.sof) $display("FAIL out_sof: got %b, required %b", out_sof, e.sof);
                else n_pass++;
            end
        end
        if (!rst && cnt_stb) stb_cnt++;
    end

    task automatic test_reset();
        #1;
        n_chk += 5;
        if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b, required 0", out_valid); else n_pass++;
        if (cn !== '0) $display("FAIL rst_cn: got %h, required 0", cn); else n_pass++;
        if ({out_sof, key_flag} !== 2'b00) $display("FAIL rst_flags: got %b, required 00", {out_sof, key_flag}); else n_pass++;
        if (ready !== 1'b1) $display("FAIL rst_ready: got %b, required 1", ready); else n_pass++;
        if ({key_count, cnt_stb} !== '0) $display("FAIL rst_stats: got %h/%b, required 0/0", key_count, cnt_stb); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_key_detect();
        send(1'b1, {10'h000, 10'h3FF, 10'h000}, {10'h123, 10'h045, 10'h300}, 10'h3FF);
        n_chk += 4;
        if (out_valid !== 1'b0) $display("FAIL lat_c1: oValid got %b, required 0", out_valid); else n_pass++;
        @(posedge clk); #1;
        if (out_valid !== 1'b0) $display("FAIL lat_c2: oValid got %b, required 0", out_valid); else n_pass++;
        @(posedge clk); #1;
        if (out_valid !== 1'b1) $display("FAIL lat_c3: oValid got %b, required 1", out_valid); else n_pass++;
        if ({cn, key_flag} !== {10'h123, 10'h045, 10'h300, 1'b1})
            $display("FAIL key_detect: got %h/%b, required 123045300/1", cn, key_flag);
        else n_pass++;
        drain();
    endtask

    task automatic test_blend();
        send(1'b1, {10'h3FF, 10'h000, 10'h200}, {10'h000, 10'h3FF, 10'h200}, 10'h200);
        send(1'b1, {10'h3FF, 10'h000, 10'h200}, {10'h000, 10'h3FF, 10'h200}, 10'h000);
        send(1'b1, {10'h3FF, 10'h000, 10'h200}, {10'h000, 10'h3FF, 10'h200}, 10'h3FF);
        send(1'b0, {10'h155, 10'h0AA, 10'h3C0}, {10'h2F0, 10'h011, 10'h07F}, 10'h3FF);
        drain();
    endtask

    task automatic test_threshold();
        send(1'b1, {10'h000, 10'h1FF, 10'h000}, {10'h111, 10'h222, 10'h333}, 10'h100);
        send(1'b0, {10'h000, 10'h200, 10'h000}, {10'h111, 10'h222, 10'h333}, 10'h100);
        send(1'b0, {10'h1FF, 10'h3FF, 10'h000}, {10'h111, 10'h222, 10'h333}, 10'h100);
        send(1'b0, {10'h000, 10'h3FF, 10'h1FE}, {10'h111, 10'h222, 10'h333}, 10'h100);
        send(1'b0, {10'h000, 10'h3FF, 10'h1FF}, {10'h111, 10'h222, 10'h333}, 10'h100);
        drain();
    endtask

    task automatic test_back_to_back();
        int stalls = 0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(i == 0, {CW'($urandom), CW'($urandom), CW'($urandom)},
                         {CW'($urandom), CW'($urandom), CW'($urandom)}, 10'h2A5);
            end
            begin
                logic prev_stall = 1'b0;
                logic [3*CW-1:0] held = '0;
                for (int i = 0; i < 40; i++) begin
                    out_ready_ds = (i % 3 == 0);
                    @(negedge clk);
                    if (out_valid && !out_ready_ds) begin
                        stalls++;
                        n_chk++;
                        if (ready !== 1'b0) $display("FAIL stall_ready: got %b, required 0", ready); else n_pass++;
                        if (prev_stall) begin
                            n_chk++;
                            if (cn !== held) $display("FAIL stall_hold: got %h, required %h", cn, held); else n_pass++;
                        end
                        held = cn;
                        prev_stall = 1'b1;
                    end else begin
                        prev_stall = 1'b0;
                    end
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready_ds = 1'b1;
        n_chk++;
        if (stalls == 0) $display("FAIL stall_seen: got 0 stalled cycles, required >0"); else n_pass++;
        drain();
    endtask

    task automatic test_alpha_latch();
        send(1'b1, {10'h100, 10'h200, 10'h300}, {10'h300, 10'h100, 10'h050}, 10'h3FF);
        for (int i = 0; i < 3; i++)
            send(1'b0, {10'h100, 10'h200, 10'h300}, {10'h300, 10'h100, 10'h050}, 10'h000);
        send(1'b1, {10'h100, 10'h200, 10'h300}, {10'h300, 10'h100, 10'h050}, 10'h000);
        send(1'b0, {10'h100, 10'h200, 10'h300}, {10'h300, 10'h100, 10'h050}, 10'h3FF);
        drain();
    endtask

    task automatic test_stats();
        int s0;
        for (int i = 0; i < 10; i++) begin
            if (i == 0 || i == 3 || i == 5 || i == 9)
                send(i == 0, {10'h000, 10'h3FF, 10'h000}, {10'h0F0, 10'h00F, 10'h3F0}, 10'h180);
            else
                send(1'b0, {10'h200, 10'h100, 10'h050}, {10'h0F0, 10'h00F, 10'h3F0}, 10'h180);
        end
        drain();
        s0 = stb_cnt;
        send(1'b1, {10'h200, 10'h100, 10'h050}, {10'h0F0, 10'h00F, 10'h3F0}, 10'h180);
        drain();
        n_chk += 2;
`ifdef CHROMA_STATS_EN
        if (stb_cnt - s0 !== 1) $display("FAIL stats_stb: got %0d pulses, required 1", stb_cnt - s0); else n_pass++;
        if (key_count !== NW'(4)) $display("FAIL stats_count: got %0d, required 4", key_count); else n_pass++;
`else
        if (stb_cnt !== 0) $display("FAIL stats_stb_off: got %0d pulses, required 0", stb_cnt); else n_pass++;
        if (key_count !== '0) $display("FAIL stats_count_off: got %0d, required 0", key_count); else n_pass++;
`endif
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 4; i++)
            send(i == 0, {10'h080, 10'h040, 10'h020}, {10'h3C0, 10'h1E0, 10'h0F0}, 10'h3FF);
        n_chk += 2;
        if (out_valid !== 1'b1) $display("FAIL pre_rst_valid: got %b, required 1", out_valid); else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        if (out_valid !== 1'b0) $display("FAIL async_rst_valid: got %b, required 0", out_valid); else n_pass++;
        sb.delete();
        m_alpha = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        send(1'b0, {10'h080, 10'h040, 10'h020}, {10'h3C0, 10'h1E0, 10'h0F0}, 10'h3FF);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_key_detect();
        test_blend();
        test_threshold();
        test_back_to_back();
        test_alpha_latch();
        test_stats();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
